axis_unpack_ctrl: RTL and testbench

AXIS_UNPACK_CTRL -- requirements
Module: axis_unpack_ctrl

---
 rtl/upsample_pkg.sv | 24 ++
 rtl/pix_xy_counter.sv | 48 ++++
 rtl/axis_unpack_ctrl.sv | 158 +++++++++++++++
 tb/tb_axis_unpack_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
// Shared definitions for the AXIS pixel unpack control path: FSM states,
// default dimension width and the word/pixel packing ratio.
package upsample_pkg;

  localparam int unsigned DimW = 12;

  // Three 32-bit words carry exactly four 24-bit pixels.
  localparam int unsigned PackWords  = 3;
  localparam int unsigned PackPixels = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSof,
    StActive,
    StDrain
  } ctrl_state_e;

  // Number of bus words that make up one line of hsize pixels.
  function automatic int unsigned words_per_line(int unsigned hsize,
                                                 int unsigned group_words = PackWords);
    return (hsize / PackPixels) * group_words;
  endfunction

endpackage

// File: rtl/pix_xy_counter.sv
// Output-side pixel position tracker: counts transferred pixels across a frame
// and decodes start-of-frame, end-of-line and final-pixel flags.
module pix_xy_counter
  import upsample_pkg::*;
#(
  parameter int unsigned DIM_W = DimW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             valid,
  input  logic [DIM_W-1:0] hsize,
  input  logic [DIM_W-1:0] vsize,
  output logic             sof,
  output logic             eol,
  output logic             last
);

  localparam logic [DIM_W-1:0] DimOne = DIM_W'(1);

  logic [DIM_W-1:0] pix_x_q;
  logic [DIM_W-1:0] line_y_q;
  logic             x_last;
  logic             y_last;

  assign x_last = (pix_x_q == hsize - DimOne);
  assign y_last = (line_y_q == vsize - DimOne);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x_q  <= '0;
      line_y_q <= '0;
    end else if (advance) begin
      if (x_last) begin
        pix_x_q  <= '0;
        // Wrapping y on the final pixel leaves the counters ready for the next frame.
        line_y_q <= y_last ? '0 : line_y_q + DimOne;
      end else begin
        pix_x_q <= pix_x_q + DimOne;
      end
    end
  end

  assign sof  = valid & (pix_x_q == '0) & (line_y_q == '0);
  assign eol  = valid & x_last;
  assign last = x_last & y_last;

endmodule

// File: rtl/axis_unpack_ctrl.sv
// Frame-level control for an AXIS word-to-pixel unpacker: SOF alignment, line
// structure checking, drain of the final pixels and frame completion pulse.
module axis_unpack_ctrl
  import upsample_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned PIXEL_WIDTH          = 24,
  parameter int unsigned DIM_W                = DimW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIM_W-1:0] cfg_hsize,
  input  logic [DIM_W-1:0] cfg_vsize,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             unp_wren,
  output logic             unp_rden,
  input  logic             unp_stuck,
  input  logic             unp_eff,
  output logic             m_pix_valid,
  input  logic             m_pix_ready,
  output logic             m_pix_sof,
  output logic             m_pix_eol,
  output logic             frame_done,
  output logic             err_line,
  output logic             err_sof,
  output logic             busy
);

  localparam int unsigned GroupWords = (PIXEL_WIDTH * PackPixels) / C_S_AXIS_TDATA_WIDTH;
  localparam logic [DIM_W-1:0] DimOne = DIM_W'(1);

  ctrl_state_e      state_q;
  logic [DIM_W-1:0] hsize_q;
  logic [DIM_W-1:0] vsize_q;
  logic [DIM_W-1:0] word_cnt_q;
  logic [DIM_W-1:0] line_cnt_q;
  logic             err_line_q;
  logic             err_sof_q;
  logic             frame_done_q;

  logic [DIM_W-1:0] last_word;
  logic             word_accept;
  logic             sof_accept;
  logic             word_last;
  logic             line_last;
  logic             pix_xfer;
  logic             pix_last;

  assign last_word   = DIM_W'(words_per_line(32'(hsize_q), GroupWords) - 1);
  assign word_last   = (word_cnt_q == last_word);
  assign line_last   = (line_cnt_q == vsize_q - DimOne);
  assign word_accept = s_axis_tvalid & s_axis_tready;
  assign sof_accept  = s_axis_tvalid & s_axis_tuser & !unp_stuck;

  // The unpacker's output slot is free whenever it is empty or being drained.
  assign m_pix_valid = unp_eff;
  assign unp_rden    = m_pix_ready | !unp_eff;
  assign pix_xfer    = m_pix_valid & m_pix_ready;

  always_comb begin
    s_axis_tready = 1'b0;
    unp_wren      = 1'b0;
    unique case (state_q)
      StWaitSof: begin
        // Non-SOF words are swallowed; the SOF word waits for unpacker room.
        s_axis_tready = (s_axis_tvalid & s_axis_tuser) ? !unp_stuck : 1'b1;
        unp_wren      = s_axis_tvalid & s_axis_tuser;
      end
      StActive: begin
        s_axis_tready = !unp_stuck;
        unp_wren      = s_axis_tvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hsize_q      <= '0;
      vsize_q      <= '0;
      word_cnt_q   <= '0;
      line_cnt_q   <= '0;
      err_line_q   <= 1'b0;
      err_sof_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) state_q <= StWaitSof;
        end
        StWaitSof: begin
          if (sof_accept) begin
            state_q    <= StActive;
            hsize_q    <= cfg_hsize;
            vsize_q    <= cfg_vsize;
            word_cnt_q <= DimOne;
            line_cnt_q <= '0;
            // Word 0 can never be the last word of a line (hsize >= 4).
            if (s_axis_tlast) err_line_q <= 1'b1;
          end else if (!enable) begin
            state_q <= StIdle;
          end
        end
        StActive: begin
          if (word_accept) begin
            if (s_axis_tuser) err_sof_q <= 1'b1;
            if (word_last) begin
              if (!s_axis_tlast) err_line_q <= 1'b1;
              word_cnt_q <= '0;
              if (line_last) begin
                state_q    <= StDrain;
                line_cnt_q <= '0;
              end else begin
                line_cnt_q <= line_cnt_q + DimOne;
              end
            end else begin
              if (s_axis_tlast) err_line_q <= 1'b1;
              word_cnt_q <= word_cnt_q + DimOne;
            end
          end
        end
        StDrain: begin
          if (pix_xfer && pix_last) begin
            frame_done_q <= 1'b1;
            state_q      <= enable ? StWaitSof : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pix_xy_counter #(
    .DIM_W(DIM_W)
  ) u_pix_xy (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(pix_xfer),
    .valid  (unp_eff),
    .hsize  (hsize_q),
    .vsize  (vsize_q),
    .sof    (m_pix_sof),
    .eol    (m_pix_eol),
    .last   (pix_last)
  );

  assign frame_done = frame_done_q;
  assign err_line   = err_line_q;
  assign err_sof    = err_sof_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_axis_unpack_ctrl.sv
// Bench for axis_unpack_ctrl with a 32->24 bit unpacker alongside; pixel stream
// expectations come from slicing a generated pixel list into bus words.
module tb_axis_unpack_ctrl;

  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] cfg_hsize = DW'(8);
  logic [DW-1:0] cfg_vsize = DW'(2);
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [31:0]   tdata = '0;
  logic          unp_wren, unp_rden, unp_stuck, unp_eff;
  logic          m_pix_valid, m_pix_sof, m_pix_eol;
  logic          m_pix_ready = 1'b1;
  logic          frame_done, err_line, err_sof, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_unpack_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_hsize    (cfg_hsize),
    .cfg_vsize    (cfg_vsize),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .unp_wren     (unp_wren),
    .unp_rden     (unp_rden),
    .unp_stuck    (unp_stuck),
    .unp_eff      (unp_eff),
    .m_pix_valid  (m_pix_valid),
    .m_pix_ready  (m_pix_ready),
    .m_pix_sof    (m_pix_sof),
    .m_pix_eol    (m_pix_eol),
    .frame_done   (frame_done),
    .err_line     (err_line),
    .err_sof      (err_sof),
    .busy         (busy)
  );

  // Unpacker: LSB-first bit buffer, one 24-bit pixel out per free output slot.
  logic [63:0] ub_q;
  logic [6:0]  un_q;
  logic [23:0] pix_data;
  logic        ueff_q;
  logic [95:0] ub_c;
  logic [6:0]  un_c;
  logic        ld_c;

  assign unp_stuck = (un_q >= 7'd24) || !unp_rden;
  assign unp_eff   = ueff_q;

  always_comb begin
    ub_c = {32'd0, ub_q};
    un_c = un_q;
    ld_c = 1'b0;
    if (unp_wren && !unp_stuck) begin
      ub_c = ub_c | ({64'd0, tdata} << un_c);
      un_c = un_c + 7'd32;
    end
    if (unp_rden && un_c >= 7'd24) ld_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ub_q     <= '0;
      un_q     <= '0;
      pix_data <= '0;
      ueff_q   <= 1'b0;
    end else begin
      if (unp_rden) begin
        ueff_q   <= ld_c;
        pix_data <= ub_c[23:0];
      end
      ub_q <= ld_c ? ub_c[87:24] : ub_c[63:0];
      un_q <= ld_c ? un_c - 7'd24 : un_c;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_wren"}, unp_wren, 0);
    check({tag, "_pix_valid"}, m_pix_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_err_line"}, err_line, 0);
    check({tag, "_err_sof"}, err_sof, 0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // rdy_mode: 0 always ready, 1 toggling, 2 random. Negative indices disable options.
  task automatic run_frame(input int hs, input int vs, input int n_junk, input int tlast_bad,
                           input int tuser_bad, input int abort_at, input int drop_en_at,
                           input int rdy_mode, input int gap, input bit do_rst,
                           input string tag);
    int wpl = (hs / 4) * 3;
    int nw = wpl * vs;
    int np = hs * vs;
    logic [23:0] pix[$];
    logic [31:0] words[$];
    logic [23:0] gp[$];
    bit gsof[$];
    bit geol[$];
    int wi = 0, ji = 0, cyc = 0, fd_cnt = 0, viol = 0, post = 0;
    int fa = -1, fv = -1;
    bit acc = 1'b0, finished = 1'b0;

    for (int i = 0; i < np; i++) pix.push_back(24'($urandom));
    for (int k = 0; k < nw; k++) begin
      logic [31:0] w;
      for (int b = 0; b < 32; b++) begin
        logic [23:0] p;
        p    = pix[(32 * k + b) / 24];
        w[b] = p[(32 * k + b) % 24];
      end
      words.push_back(w);
    end

    cfg_hsize = DW'(hs);
    cfg_vsize = DW'(vs);
    if (do_rst) do_reset();
    enable = 1'b1;

    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (acc) s_axis_tvalid = 1'b0;
      acc = 1'b0;
      if (abort_at >= 0 && wi == abort_at) begin
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check_reset_outputs({tag, "_midrst"});
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (drop_en_at >= 0 && wi >= drop_en_at) enable = 1'b0;
      case (rdy_mode)
        0:       m_pix_ready = 1'b1;
        1:       m_pix_ready = (cyc % 2) == 0;
        default: m_pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (!s_axis_tvalid && (ji < n_junk || wi < nw) &&
          (gap == 0 || $urandom_range(0, gap) == 0)) begin
        s_axis_tvalid = 1'b1;
        if (ji < n_junk) begin
          tdata        = $urandom;
          s_axis_tuser = 1'b0;
          s_axis_tlast = 1'b0;
        end else begin
          tdata        = words[wi];
          s_axis_tuser = (wi == 0) || (wi == tuser_bad);
          s_axis_tlast = ((wi % wpl) == wpl - 1) ^ (wi == tlast_bad);
        end
      end
      #4;
      if (m_pix_valid && fv < 0) fv = cyc;
      if (m_pix_valid && m_pix_ready) begin
        gp.push_back(pix_data);
        gsof.push_back(m_pix_sof);
        geol.push_back(m_pix_eol);
      end
      if (unp_stuck && s_axis_tready) viol++;
      if (frame_done) fd_cnt++;
      if (s_axis_tvalid && s_axis_tready) begin
        acc = 1'b1;
        if (ji < n_junk) begin
          check({tag, "_junk_wren"}, unp_wren, 0);
          ji++;
        end else begin
          if (wi == 0) fa = cyc;
          wi++;
        end
      end
      if (wi == nw && fd_cnt >= 1) post++;
      if (post == 3) begin
        finished = 1'b1;
        break;
      end
    end
    s_axis_tvalid = 1'b0;

    check({tag, "_timeout"}, finished, 1);
    check({tag, "_words"}, wi, nw);
    check({tag, "_npix"}, gp.size(), np);
    for (int i = 0; i < np && i < gp.size(); i++) begin
      check({tag, "_pix"}, gp[i], pix[i]);
      check({tag, "_sof"}, gsof[i], i == 0);
      check({tag, "_eol"}, geol[i], (i % hs) == hs - 1);
    end
    check({tag, "_latency"}, fv - fa, 1);
    check({tag, "_frame_done_cnt"}, fd_cnt, 1);
    check({tag, "_err_line"}, err_line, tlast_bad >= 0);
    check({tag, "_err_sof"}, err_sof, tuser_bad > 0);
    check({tag, "_stuck_tready"}, viol, 0);
    check({tag, "_busy_end"}, busy, drop_en_at < 0);
  endtask

  typedef struct {
    logic en, tv, tu, rdy;
    logic ex_tready, ex_wren, ex_busy, ex_rden;
  } vec_t;

  vec_t vt[6];

  initial begin
    // IDLE ignores everything until enable; WAIT_SOF swallows non-SOF words.
    vt[0] = '{en: 0, tv: 1, tu: 1, rdy: 0, ex_tready: 0, ex_wren: 0, ex_busy: 0, ex_rden: 1};
    vt[1] = '{en: 0, tv: 0, tu: 0, rdy: 1, ex_tready: 0, ex_wren: 0, ex_busy: 0, ex_rden: 1};
    vt[2] = '{en: 1, tv: 0, tu: 0, rdy: 1, ex_tready: 0, ex_wren: 0, ex_busy: 0, ex_rden: 1};
    vt[3] = '{en: 1, tv: 1, tu: 0, rdy: 0, ex_tready: 1, ex_wren: 0, ex_busy: 1, ex_rden: 1};
    vt[4] = '{en: 1, tv: 0, tu: 1, rdy: 1, ex_tready: 1, ex_wren: 0, ex_busy: 1, ex_rden: 1};
    vt[5] = '{en: 1, tv: 1, tu: 0, rdy: 1, ex_tready: 1, ex_wren: 0, ex_busy: 1, ex_rden: 1};

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      enable        = vt[i].en;
      s_axis_tvalid = vt[i].tv;
      s_axis_tuser  = vt[i].tu;
      m_pix_ready   = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_tready", i), s_axis_tready, vt[i].ex_tready);
      check($sformatf("vec%0d_wren", i), unp_wren, vt[i].ex_wren);
      check($sformatf("vec%0d_busy", i), busy, vt[i].ex_busy);
      check($sformatf("vec%0d_rden", i), unp_rden, vt[i].ex_rden);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;

    // hs vs junk tlast_bad tuser_bad abort drop_en rdy gap rst tag
    run_frame(8, 2, 0, -1, -1, -1, -1, 0, 0, 1, "basic");
    run_frame(8, 2, 0, -1, -1, -1, -1, 1, 0, 1, "toggle");
    run_frame(8, 2, 3, -1, -1, -1, -1, 0, 0, 1, "junk");
    run_frame(8, 2, 0, 4, -1, -1, -1, 0, 0, 1, "tlast_err");
    run_frame(8, 2, 0, -1, 5, -1, -1, 0, 0, 1, "tuser_err");
    run_frame(8, 2, 0, -1, -1, 8, -1, 0, 0, 1, "abort");
    run_frame(8, 2, 0, -1, -1, -1, -1, 0, 0, 0, "after_abort");
    run_frame(8, 2, 0, -1, -1, -1, 5, 0, 0, 1, "drop_en");
    for (int r = 0; r < 6; r++) begin
      run_frame($urandom_range(1, 4) * 4, $urandom_range(1, 3), $urandom_range(0, 2), -1, -1,
                -1, -1, 2, 2, 0, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
